// File: rtl/pe_chain_ctrl.sv
// Sequencer for a 1-D chain of multiply-accumulate PEs: issues operand reads,
// inserts bubbles, and tags results at the chain tail with their index.
module pe_chain_ctrl #(
  parameter int NUM_PE    = 4,
  parameter int CHAIN_LAT = 4,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_avail,
  output logic             op_rd_en,
  output logic [LEN_W-1:0] op_addr,
  output logic             op_zero,
  output logic             psum_zero,
  output logic             res_valid,
  output logic [LEN_W-1:0] res_idx,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  // Handshake: start/len are taken only in IDLE; busy covers ISSUE, DRAIN and
  // DONE; done pulses for exactly one cycle; res_valid cannot be backpressured.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  if (NUM_PE < 1 || CHAIN_LAT < 1) begin : g_param_check
    $error("pe_chain_ctrl: NUM_PE and CHAIN_LAT must both be at least 1");
  end

  localparam logic [CHAIN_LAT-1:0] TAIL_MASK = CHAIN_LAT'(1) << (CHAIN_LAT - 1);

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LAT-1:0] vpipe_q, vpipe_d;
  logic [CHAIN_LAT-1:0] vpipe_lsb;
  logic                 last_issue;
  logic                 head_in_flight;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vpipe_q <= vpipe_d;
    end
  end

  assign last_issue     = op_rd_en && (({1'b0, cnt_q} + 1'b1) == {1'b0, len_q});
  // Any valid bit short of the tail means a result is still travelling.
  assign head_in_flight = |(vpipe_q & ~TAIL_MASK);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (len != '0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!head_in_flight) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_rd_en  = (state_q == S_ISSUE) && op_avail && !rst;
    op_zero   = !op_rd_en;
    psum_zero = 1'b1;
    res_valid = vpipe_q[CHAIN_LAT-1] && !rst;
    busy      = (state_q != S_IDLE) && !rst;
    done      = (state_q == S_DONE) && !rst;
    op_addr   = addr_q;
    res_idx   = idx_q;
    state_o   = state_q;
  end

  always_comb begin
    len_d     = len_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    vpipe_lsb = '0;
    vpipe_lsb[0] = op_rd_en;
    vpipe_d   = (vpipe_q << 1) | vpipe_lsb;
    if (state_q == S_IDLE && start && len != '0) begin
      len_d  = len;
      addr_d = '0;
      idx_d  = '0;
      cnt_d  = '0;
    end
    if (op_rd_en) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
    if (res_valid) idx_d = idx_q + 1'b1;
  end

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// Directed and randomised runs of pe_chain_ctrl; results are scoreboarded by
// index and arrival cycle, control outputs are checked every cycle.
module tb_pe_chain_ctrl;

  localparam int CHAIN_LAT = 4;
  localparam int LEN_W     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             op_avail;
  logic             op_rd_en;
  logic [LEN_W-1:0] op_addr;
  logic             op_zero;
  logic             psum_zero;
  logic             res_valid;
  logic [LEN_W-1:0] res_idx;
  logic             busy;
  logic             done;
  logic [1:0]       state_o;

  int checks = 0;
  int errors = 0;
  logic [LEN_W-1:0] exp_q[$];
  int               due_q[$];

  pe_chain_ctrl #(.NUM_PE(4), .CHAIN_LAT(CHAIN_LAT), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .op_avail (op_avail),
    .op_rd_en (op_rd_en),
    .op_addr  (op_addr),
    .op_zero  (op_zero),
    .psum_zero(psum_zero),
    .res_valid(res_valid),
    .res_idx  (res_idx),
    .busy     (busy),
    .done     (done),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " op_rd_en"}, 32'(op_rd_en), 0);
    chk({tag, " res_valid"}, 32'(res_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " op_zero"}, 32'(op_zero), 1);
    chk({tag, " psum_zero"}, 32'(psum_zero), 1);
    chk({tag, " op_addr"}, 32'(op_addr), 0);
    chk({tag, " res_idx"}, 32'(res_idx), 0);
  endtask

  // Called just after a rising edge; cycle 0 is the start cycle. start2 adds a
  // second (ignored) start with a different len; rst_cyc pulses reset there.
  task automatic run(input int l, input logic [63:0] lo_mask, input int start2,
                     input int rst_cyc, input int extra);
    bit    issue [0:127];
    int    cnt, last, done_c, endc, issued;
    bit    e_rd, e_rv, post;
    string t;
    for (int c = 0; c < 128; c++) issue[c] = 1'b0;
    cnt  = 0;
    last = 0;
    for (int c = 1; c < 120 && cnt < l; c++) begin
      if (!(c < 64 && lo_mask[c])) begin
        issue[c] = 1'b1;
        cnt++;
        last = c;
      end
    end
    done_c = (l == 0) ? 1 : last + CHAIN_LAT + 1;
    endc   = (rst_cyc >= 0) ? rst_cyc + 3 : done_c + extra;
    issued = 0;
    exp_q.delete();
    due_q.delete();
    for (int k = 0; k <= endc; k++) begin
      #1;
      start    = (k == 0) || (k == start2);
      len      = (k == start2) ? LEN_W'(7) : LEN_W'(l);
      op_avail = !(k < 64 && lo_mask[k]);
      rst      = (k == rst_cyc);
      @(negedge clk);
      t    = $sformatf("len=%0d cyc=%0d", l, k);
      post = (rst_cyc >= 0) && (k > rst_cyc);
      if (k == rst_cyc) begin
        exp_q.delete();
        due_q.delete();
      end else if (post) begin
        chk({t, " post-rst busy"}, 32'(busy), 0);
        chk({t, " post-rst res_valid"}, 32'(res_valid), 0);
        chk({t, " post-rst done"}, 32'(done), 0);
        chk({t, " post-rst op_rd_en"}, 32'(op_rd_en), 0);
        chk({t, " post-rst op_addr"}, 32'(op_addr), 0);
      end else begin
        e_rd = issue[k];
        chk({t, " op_rd_en"}, 32'(op_rd_en), 32'(e_rd));
        chk({t, " op_zero"}, 32'(op_zero), 32'(!e_rd));
        chk({t, " psum_zero"}, 32'(psum_zero), 1);
        chk({t, " busy"}, 32'(busy), 32'(k >= 1 && k <= done_c));
        chk({t, " done"}, 32'(done), 32'(k == done_c));
        if (e_rd) begin
          chk({t, " op_addr"}, 32'(op_addr), 32'(issued));
          exp_q.push_back(LEN_W'(issued));
          due_q.push_back(k + CHAIN_LAT);
          issued++;
        end
        e_rv = (due_q.size() > 0) && (due_q[0] == k);
        chk({t, " res_valid"}, 32'(res_valid), 32'(e_rv));
        if (e_rv) begin
          chk({t, " res_idx"}, 32'(res_idx), 32'(exp_q.pop_front()));
          void'(due_q.pop_front());
        end
      end
      @(posedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    len      = '0;
    op_avail = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("during reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("after reset");
    @(posedge clk);

    run(4, 64'h0, -1, -1, 1);        // basic run
    run(2, 64'hC, -1, -1, 1);        // bubbles in cycles 2-3
    run(0, 64'h0, -1, -1, 1);        // zero length
    run(0, 64'h0, 1, -1, 1);         // zero length, start held into DONE
    run(4, 64'h0, 3, -1, 1);         // start while busy
    run(4, 64'h0, -1, 3, 0);         // reset mid-run
    run(1, 64'h0, -1, -1, 1);        // fresh run after reset
    run(3, 64'h0, -1, -1, 0);        // back-to-back pair
    run(2, 64'h0, -1, -1, 1);
    for (int r = 0; r < 4; r++) begin
      run($urandom_range(1, 8), {$urandom, $urandom}, -1, -1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
